lsu_mem_port: RTL and testbench

Load/store unit sitting between the datapath's data-memory control signals (opcode, MemRead, MemWrite, ALU address, rt store data) and a word-wide, handshaked external data-memory bus. It initiates bus transactions, performs byte-lane alignment, byte enables and load sign/zero extension, and stalls the datapath until the transaction completes. Misaligned accesses and bus timeouts are flagged instead of hanging the core.

---
 rtl/lsu_mem_port_if.sv | 44 ++++
 rtl/lsu_mem_port.sv | 259 +++++++++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_port_if.sv
// ----------------------------------------------------------------------------
// lsu_mem_port_if
//
// Word-wide handshaked data-memory bus between the load/store unit (master)
// and the external data memory / responder (slave).
//
// Signals:
//   bus_req    master->slave  transaction request, held for the whole access
//   bus_we     master->slave  1 = write, 0 = read
//   bus_addr   master->slave  word-aligned byte address
//   bus_be     master->slave  byte enables, bit k covers bits [8k+7:8k]
//   bus_wdata  master->slave  lane-replicated write data
//   bus_rdata  slave->master  read data, valid together with bus_ack
//   bus_ack    slave->master  one-cycle completion strobe
// ----------------------------------------------------------------------------
interface lsu_mem_port_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );
endinterface

// File: rtl/lsu_mem_port.sv
// ----------------------------------------------------------------------------
// lsu_mem_port
//
// Load/store unit between the datapath's data-memory controls and a word-wide
// handshaked data-memory bus. Decodes the access, checks alignment, builds
// byte enables and lane-replicated write data, extends load data, and stalls
// the core until the bus transaction completes or times out.
//
// Parameters:
//   TIMEOUT     REQ cycles without bus_ack before the access is aborted (1..255)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   opcode      instruction opcode (lb/lh/lw/lbu/lhu/sb/sh/sw recognised)
//   mem_read    datapath load request (level)
//   mem_write   datapath store request (level)
//   addr        byte address from the ALU
//   store_data  store operand (low byte / halfword used for sb / sh)
//   load_data   extended load result, valid in DONE, held until next load/timeout
//   stall       combinational: freeze PC and pipeline writes while high
//   misalign    one-cycle pulse: a misaligned access was rejected
//   timeout     one-cycle pulse (in DONE): bus_ack never arrived
//   bus         master side of the data-memory bus
// ----------------------------------------------------------------------------
module lsu_mem_port #(
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [5:0]     opcode,
    input  logic           mem_read,
    input  logic           mem_write,
    input  logic [31:0]    addr,
    input  logic [31:0]    store_data,
    output logic [31:0]    load_data,
    output logic           stall,
    output logic           misalign,
    output logic           timeout,
    lsu_mem_port_if.master bus
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    // Last counter value before the abort fires.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic        misalign_q, misalign_d;
    logic        timeout_q, timeout_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic is_load, is_store;
    logic size_byte, size_half, size_word;
    logic req_valid, req_aligned, in_idle, req_accept, req_misalign;

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        size_byte = 1'b0;
        size_half = 1'b0;
        size_word = 1'b0;
        case (opcode)
            OP_LB, OP_LBU: begin is_load  = 1'b1; size_byte = 1'b1; end
            OP_LH, OP_LHU: begin is_load  = 1'b1; size_half = 1'b1; end
            OP_LW:         begin is_load  = 1'b1; size_word = 1'b1; end
            OP_SB:         begin is_store = 1'b1; size_byte = 1'b1; end
            OP_SH:         begin is_store = 1'b1; size_half = 1'b1; end
            OP_SW:         begin is_store = 1'b1; size_word = 1'b1; end
            default:       ;
        endcase
    end

    // Exactly one request line, and it must match the opcode class.
    assign req_valid   = (is_load  & mem_read  & ~mem_write) |
                         (is_store & mem_write & ~mem_read);
    assign req_aligned = size_byte |
                         (size_half & ~addr[0]) |
                         (size_word & (addr[1:0] == 2'b00));
    assign in_idle      = (state_q == S_IDLE);
    assign req_accept   = in_idle & req_valid &  req_aligned;
    assign req_misalign = in_idle & req_valid & ~req_aligned;

    // ------------------------------------------------------------------
    // Store lane mapping (little endian). Reads enable all four lanes.
    // ------------------------------------------------------------------
    logic [3:0]  be_new;
    logic [31:0] wdata_new;

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = 32'h0;
        if (is_store) begin
            if (size_byte) begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{store_data[7:0]}};
            end else if (size_half) begin
                be_new    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{store_data[15:0]}};
            end else begin
                be_new    = 4'b1111;
                wdata_new = store_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load extraction from the returned word, using the captured offset.
    // ------------------------------------------------------------------
    logic [7:0]  rd_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;

    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
        assign rd_byte[gi] = bus.bus_rdata[8*gi +: 8];
    end

    always_comb begin
        sel_byte = rd_byte[off_q];
        sel_half = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (op_q)
            OP_LB:   load_ext = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_ext = {24'h0, sel_byte};
            OP_LH:   load_ext = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_ext = {16'h0, sel_half};
            default: load_ext = bus.bus_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        off_d       = off_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        load_data_d = load_data_q;
        misalign_d  = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                misalign_d = req_misalign;
                if (req_accept) begin
                    state_d     = S_REQ;
                    cnt_d       = 8'd0;
                    op_d        = opcode;
                    off_d       = addr[1:0];
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_store;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_be_d    = be_new;
                    bus_wdata_d = wdata_new;
                end
            end
            S_REQ: begin
                // Ack wins over an abort on the same edge.
                if (bus.bus_ack) begin
                    state_d   = S_DONE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        load_data_d = load_ext;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_DONE;
                    bus_req_d   = 1'b0;
                    timeout_d   = 1'b1;
                    load_data_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            // One cycle with stall low lets the core retire the access
            // before a new request can be sampled.
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            op_q        <= 6'd0;
            off_q       <= 2'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
            load_data_q <= 32'h0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            off_q       <= off_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            load_data_q <= load_data_d;
            misalign_q  <= misalign_d;
            timeout_q   <= timeout_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign stall         = req_accept | (state_q == S_REQ);
    assign load_data     = load_data_q;
    assign misalign      = misalign_q;
    assign timeout       = timeout_q;
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// ----------------------------------------------------------------------------
// tb_lsu_mem_port
//
// Self-checking bench for lsu_mem_port (TIMEOUT = 4). Each scenario task
// pushes its expected transaction onto a scoreboard queue, drives the access,
// then pops the expectation and compares it with what the bus and datapath
// outputs showed during that access.
// ----------------------------------------------------------------------------
module tb_lsu_mem_port;

    localparam int TMO = 4;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        stall;
    logic        misalign;
    logic        timeout;

    lsu_mem_port_if bus_if();

    lsu_mem_port #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .store_data (store_data),
        .load_data  (load_data),
        .stall      (stall),
        .misalign   (misalign),
        .timeout    (timeout),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          ack_after;   // REQ cycles before ack; -1 = never
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_val;       // load result, write data, or misalign flag
        int          e_stalls;
    } vec_t;

    vec_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] last_load = 32'h0;

    // Observations gathered during one access.
    logic        o_req, o_we, o_stable, o_done, o_tmo_done, o_mis1;
    logic [31:0] o_addr, o_wdata, o_load;
    logic [3:0]  o_be;
    int          o_stalls, o_tmo_n, o_mis_n;

    // Present one request for a single cycle, answer the bus, and record
    // what the DUT did until DONE (or until it is clear nothing started).
    task automatic run_access(input logic [5:0] op, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] sd,
                              input int ack_after, input logic [31:0] rdata);
        int  req_n;
        bit  fin;
        o_req = 0; o_we = 0; o_addr = 0; o_be = 0; o_wdata = 0; o_stable = 1;
        o_done = 0; o_load = 32'hx; o_tmo_done = 0; o_mis1 = 0;
        o_stalls = 0; o_tmo_n = 0; o_mis_n = 0;
        req_n = 0;
        fin = 0;
        @(negedge clk);
        opcode = op; mem_read = rd; mem_write = wr; addr = a; store_data = sd;
        bus_if.bus_rdata = rdata;
        bus_if.bus_ack = 1'b0;
        #1;
        for (int c = 0; c < 40 && !fin; c++) begin
            if (stall)    o_stalls++;
            if (misalign) o_mis_n++;
            if (timeout)  o_tmo_n++;
            if (c == 1)   o_mis1 = misalign;
            if (bus_if.bus_req) begin
                if (req_n == 0) begin
                    o_req = 1; o_we = bus_if.bus_we; o_addr = bus_if.bus_addr;
                    o_be = bus_if.bus_be; o_wdata = bus_if.bus_wdata;
                end else if ({bus_if.bus_we, bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata}
                             !== {o_we, o_addr, o_be, o_wdata}) begin
                    o_stable = 0;
                end
                bus_if.bus_ack = (req_n == ack_after);
                req_n++;
            end else begin
                bus_if.bus_ack = 1'b0;
                if (req_n > 0) begin
                    o_done = 1; o_load = load_data; o_tmo_done = timeout;
                    fin = 1;
                end else if (c >= 3) begin
                    fin = 1;
                end
            end
            if (!fin) begin
                @(negedge clk);
                if (c == 0) begin
                    mem_read = 1'b0;
                    mem_write = 1'b0;
                end
                #1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        opcode = 6'd0; mem_read = 0; mem_write = 0; addr = 0; store_data = 0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (bus_if.bus_req !== 1'b0) begin n_err++; $display("FAIL reset bus_req got=%b exp=0", bus_if.bus_req); end
        n_vec++; if (bus_if.bus_we !== 1'b0) begin n_err++; $display("FAIL reset bus_we got=%b exp=0", bus_if.bus_we); end
        n_vec++; if (bus_if.bus_addr !== 32'h0) begin n_err++; $display("FAIL reset bus_addr got=%h exp=0", bus_if.bus_addr); end
        n_vec++; if (bus_if.bus_be !== 4'h0) begin n_err++; $display("FAIL reset bus_be got=%h exp=0", bus_if.bus_be); end
        n_vec++; if (bus_if.bus_wdata !== 32'h0) begin n_err++; $display("FAIL reset bus_wdata got=%h exp=0", bus_if.bus_wdata); end
        n_vec++; if (load_data !== 32'h0) begin n_err++; $display("FAIL reset load_data got=%h exp=0", load_data); end
        n_vec++; if ({stall, misalign, timeout} !== 3'b000) begin n_err++; $display("FAIL reset stall/mis/tmo got=%b exp=000", {stall, misalign, timeout}); end
        rst_n = 1'b1;
    endtask

    task automatic test_loads();
        vec_t tbl[8];
        vec_t e;
        tbl[0] = '{OP_LB,  1'b1, 1'b0, 32'h13, 32'h0, 32'h80FF7F01, 0, 32'h10, 4'hF, 32'hFFFFFF80, 2};
        tbl[1] = '{OP_LBU, 1'b1, 1'b0, 32'h13, 32'h0, 32'h80FF7F01, 0, 32'h10, 4'hF, 32'h00000080, 2};
        tbl[2] = '{OP_LB,  1'b1, 1'b0, 32'h11, 32'h0, 32'h80FF7F01, 0, 32'h10, 4'hF, 32'h0000007F, 2};
        tbl[3] = '{OP_LH,  1'b1, 1'b0, 32'h02, 32'h0, 32'h80011234, 0, 32'h00, 4'hF, 32'hFFFF8001, 2};
        tbl[4] = '{OP_LHU, 1'b1, 1'b0, 32'h02, 32'h0, 32'h80011234, 1, 32'h00, 4'hF, 32'h00008001, 3};
        tbl[5] = '{OP_LH,  1'b1, 1'b0, 32'h00, 32'h0, 32'h80011234, 0, 32'h00, 4'hF, 32'h00001234, 2};
        tbl[6] = '{OP_LW,  1'b1, 1'b0, 32'h44, 32'h0, 32'h12345678, 2, 32'h44, 4'hF, 32'h12345678, 4};
        tbl[7] = '{OP_LBU, 1'b1, 1'b0, 32'h4A, 32'h0, 32'hA1B2C3D4, 0, 32'h48, 4'hF, 32'h000000B2, 2};
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(tbl[i]);
            run_access(tbl[i].op, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].sd, tbl[i].ack_after, tbl[i].rdata);
            e = exp_q.pop_front();
            n_vec++; if ({o_req, o_we} !== 2'b10) begin n_err++; $display("FAIL load[%0d] req/we got=%b%b exp=10", i, o_req, o_we); end
            n_vec++; if (o_addr !== e.e_addr) begin n_err++; $display("FAIL load[%0d] bus_addr got=%h exp=%h", i, o_addr, e.e_addr); end
            n_vec++; if (o_be !== e.e_be) begin n_err++; $display("FAIL load[%0d] bus_be got=%b exp=%b", i, o_be, e.e_be); end
            n_vec++; if (o_stable !== 1'b1) begin n_err++; $display("FAIL load[%0d] bus_hold got=%b exp=1", i, o_stable); end
            n_vec++; if (o_stalls != e.e_stalls) begin n_err++; $display("FAIL load[%0d] stall_cycles got=%0d exp=%0d", i, o_stalls, e.e_stalls); end
            n_vec++; if (o_load !== e.e_val) begin n_err++; $display("FAIL load[%0d] load_data got=%h exp=%h", i, o_load, e.e_val); end
            n_vec++; if (o_tmo_n != 0) begin n_err++; $display("FAIL load[%0d] timeout_pulses got=%0d exp=0", i, o_tmo_n); end
            last_load = e.e_val;
        end
    endtask

    task automatic test_stores();
        vec_t tbl[5];
        vec_t e;
        // sh with ack on the last permitted REQ cycle: success, no timeout.
        tbl[0] = '{OP_SH, 1'b0, 1'b1, 32'h22, 32'h1234ABCD, 32'hFFFFFFFF, 3, 32'h20, 4'b1100, 32'hABCDABCD, 5};
        tbl[1] = '{OP_SW, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 32'h40, 4'b1111, 32'hDEADBEEF, 2};
        tbl[2] = '{OP_SB, 1'b0, 1'b1, 32'h01, 32'h000000A5, 32'hFFFFFFFF, 0, 32'h00, 4'b0010, 32'hA5A5A5A5, 2};
        tbl[3] = '{OP_SB, 1'b0, 1'b1, 32'h07, 32'h123456C3, 32'hFFFFFFFF, 0, 32'h04, 4'b1000, 32'hC3C3C3C3, 2};
        tbl[4] = '{OP_SH, 1'b0, 1'b1, 32'h10, 32'h9999BEEF, 32'hFFFFFFFF, 1, 32'h10, 4'b0011, 32'hBEEFBEEF, 3};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(tbl[i]);
            run_access(tbl[i].op, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].sd, tbl[i].ack_after, tbl[i].rdata);
            e = exp_q.pop_front();
            n_vec++; if ({o_req, o_we} !== 2'b11) begin n_err++; $display("FAIL store[%0d] req/we got=%b%b exp=11", i, o_req, o_we); end
            n_vec++; if (o_addr !== e.e_addr) begin n_err++; $display("FAIL store[%0d] bus_addr got=%h exp=%h", i, o_addr, e.e_addr); end
            n_vec++; if (o_be !== e.e_be) begin n_err++; $display("FAIL store[%0d] bus_be got=%b exp=%b", i, o_be, e.e_be); end
            n_vec++; if (o_wdata !== e.e_val) begin n_err++; $display("FAIL store[%0d] bus_wdata got=%h exp=%h", i, o_wdata, e.e_val); end
            n_vec++; if (o_stable !== 1'b1) begin n_err++; $display("FAIL store[%0d] bus_hold got=%b exp=1", i, o_stable); end
            n_vec++; if (o_stalls != e.e_stalls) begin n_err++; $display("FAIL store[%0d] stall_cycles got=%0d exp=%0d", i, o_stalls, e.e_stalls); end
            n_vec++; if (o_load !== last_load) begin n_err++; $display("FAIL store[%0d] load_data_hold got=%h exp=%h", i, o_load, last_load); end
            n_vec++; if (o_tmo_n != 0) begin n_err++; $display("FAIL store[%0d] timeout_pulses got=%0d exp=0", i, o_tmo_n); end
        end
    endtask

    task automatic test_misalign_invalid();
        vec_t tbl[9];
        vec_t e;
        tbl[0] = '{OP_LW,  1'b1, 1'b0, 32'h06, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'd1, 0};
        tbl[1] = '{OP_SH,  1'b0, 1'b1, 32'h03, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'd1, 0};
        tbl[2] = '{OP_LHU, 1'b1, 1'b0, 32'h01, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'd1, 0};
        tbl[3] = '{OP_SW,  1'b0, 1'b1, 32'h02, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'd1, 0};
        tbl[4] = '{OP_LW,  1'b1, 1'b1, 32'h08, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'd0, 0};
        tbl[5] = '{6'd0,   1'b1, 1'b0, 32'h00, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'd0, 0};
        tbl[6] = '{OP_LW,  1'b0, 1'b1, 32'h00, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'd0, 0};
        tbl[7] = '{OP_SB,  1'b1, 1'b0, 32'h00, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'd0, 0};
        tbl[8] = '{OP_LW,  1'b1, 1'b1, 32'h06, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'd0, 0};
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(tbl[i]);
            run_access(tbl[i].op, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].sd, tbl[i].ack_after, tbl[i].rdata);
            e = exp_q.pop_front();
            n_vec++; if (o_req !== 1'b0) begin n_err++; $display("FAIL reject[%0d] bus_req got=%b exp=0", i, o_req); end
            n_vec++; if (o_stalls != 0) begin n_err++; $display("FAIL reject[%0d] stall_cycles got=%0d exp=0", i, o_stalls); end
            n_vec++; if (o_mis1 !== e.e_val[0]) begin n_err++; $display("FAIL reject[%0d] misalign_next got=%b exp=%b", i, o_mis1, e.e_val[0]); end
            n_vec++; if (o_mis_n != int'(e.e_val)) begin n_err++; $display("FAIL reject[%0d] misalign_pulses got=%0d exp=%0d", i, o_mis_n, e.e_val); end
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        opcode = OP_LW; mem_read = 1'b1; mem_write = 1'b0; addr = 32'h20;
        bus_if.bus_ack = 1'b0;
        @(negedge clk);
        mem_read = 1'b0;
        #1;
        seen = bus_if.bus_req ? 1 : 0;
        n_vec++; if (seen != 1) begin n_err++; $display("FAIL reset_mid bus_req_up got=%0d exp=1", seen); end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        n_vec++; if (bus_if.bus_req !== 1'b0) begin n_err++; $display("FAIL reset_mid bus_req got=%b exp=0", bus_if.bus_req); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_mid stall got=%b exp=0", stall); end
        n_vec++; if (load_data !== 32'h0) begin n_err++; $display("FAIL reset_mid load_data got=%h exp=0", load_data); end
        rst_n = 1'b1;
        last_load = 32'h0;
        // A fresh access must start from IDLE with the minimum latency.
        run_access(OP_LBU, 1'b1, 1'b0, 32'h13, 32'h0, 0, 32'h80FF7F01);
        n_vec++; if (o_stalls != 2) begin n_err++; $display("FAIL reset_mid post_stalls got=%0d exp=2", o_stalls); end
        n_vec++; if (o_load !== 32'h00000080) begin n_err++; $display("FAIL reset_mid post_load got=%h exp=00000080", o_load); end
    endtask

    task automatic test_timeout();
        run_access(OP_LW, 1'b1, 1'b0, 32'h8, 32'h0, -1, 32'h55555555);
        n_vec++; if (o_addr !== 32'h8) begin n_err++; $display("FAIL timeout bus_addr got=%h exp=00000008", o_addr); end
        n_vec++; if (o_stalls != 1 + TMO) begin n_err++; $display("FAIL timeout stall_cycles got=%0d exp=%0d", o_stalls, 1 + TMO); end
        n_vec++; if (o_done !== 1'b1) begin n_err++; $display("FAIL timeout reached_done got=%b exp=1", o_done); end
        n_vec++; if (o_tmo_done !== 1'b1) begin n_err++; $display("FAIL timeout pulse_in_done got=%b exp=1", o_tmo_done); end
        n_vec++; if (o_tmo_n != 1) begin n_err++; $display("FAIL timeout pulse_count got=%0d exp=1", o_tmo_n); end
        n_vec++; if (o_load !== 32'h0) begin n_err++; $display("FAIL timeout load_data got=%h exp=0", o_load); end
        // A late ack while idle must not disturb anything.
        @(negedge clk);
        bus_if.bus_rdata = 32'h12345678;
        bus_if.bus_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_vec++; if ({bus_if.bus_req, stall, timeout} !== 3'b000) begin n_err++; $display("FAIL idle_ack[%0d] req/stall/tmo got=%b exp=000", i, {bus_if.bus_req, stall, timeout}); end
            n_vec++; if (load_data !== 32'h0) begin n_err++; $display("FAIL idle_ack[%0d] load_data got=%h exp=0", i, load_data); end
        end
        bus_if.bus_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_misalign_invalid();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
